frame_link_arbiter: RTL and testbench

Shares the single framed RS-232 link between two frame producers. Sits in front of the link `Interface` block and drives its `fin`/`fin_valid` transmit port. It watches the returned PC confirmation (`conf_from_PC`/`conf_from_PC_valid`) to sequence each frame to completion, retrying on error and aborting on fatal error. It never starts a transmission while the link is receiving (`semafor_out` high).

---
 rtl/frame_link_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_frame_link_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_link_arbiter.sv
// frame_link_arbiter
// Shares one framed RS-232 link between two frame producers. A round-robin
// pointer picks the owner, the owner's frame is strobed into the link, and the
// PC confirmation code decides between completion, resend and abort.

module frame_link_arbiter #(
    parameter int         FRAME_SIZE     = 599,
    parameter int         MAX_RETRY      = 3,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         GAP_CYCLES     = 32,
    parameter logic [7:0] OKAY           = 8'h05,
    parameter logic [7:0] ERROR          = 8'h04,
    parameter logic [7:0] FATAL_ERROR    = 8'h08
) (
    input  logic                clk,
    input  logic                init,
    input  logic [1:0]          req,
    input  logic [0:FRAME_SIZE] frame0,
    input  logic [0:FRAME_SIZE] frame1,
    output logic [1:0]          done,
    output logic [1:0]          fail,
    output logic [1:0]          grant,
    output logic                fatal,
    output logic [0:FRAME_SIZE] fin,
    output logic                fin_valid,
    input  logic                link_busy,
    input  logic [7:0]          conf_from_PC,
    input  logic                conf_from_PC_valid
);

    localparam int              RW         = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [31:0]     TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]     GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]     TIMER_SAT  = 32'hFFFF_FFFF;
    localparam logic [RW-1:0]   RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_CONF,
        S_GAP,
        S_FATAL
    } state_t;

    state_t              state_q, state_d;
    logic [0:FRAME_SIZE] fin_q, fin_d;
    logic                finValid_q, finValid_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          done_q, done_d;
    logic [1:0]          fail_q, fail_d;
    logic                fatal_q, fatal_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [31:0]         timer_q, timer_d;
    logic [31:0]         gapCnt_q, gapCnt_d;
    logic                ptr_q, ptr_d;
    logic                resend_q, resend_d;
    logic                confPrev_q;
    logic                confRise;
    logic                sel;
    logic                attemptFailed;

    // A confirmation counts only on the cycle its valid level first rises.
    assign confRise = conf_from_PC_valid & ~confPrev_q;

    assign fin       = fin_q;
    assign fin_valid = finValid_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fatal     = fatal_q;

    // State and output registers; init clears everything immediately.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q    <= S_IDLE;
            fin_q      <= '0;
            finValid_q <= 1'b0;
            grant_q    <= 2'b00;
            done_q     <= 2'b00;
            fail_q     <= 2'b00;
            fatal_q    <= 1'b0;
            retry_q    <= '0;
            timer_q    <= '0;
            gapCnt_q   <= '0;
            ptr_q      <= 1'b0;
            resend_q   <= 1'b0;
            confPrev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fin_q      <= fin_d;
            finValid_q <= finValid_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            fatal_q    <= fatal_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            gapCnt_q   <= gapCnt_d;
            ptr_q      <= ptr_d;
            resend_q   <= resend_d;
            confPrev_q <= conf_from_PC_valid;
        end
    end

    // Next-state logic: arbitration, strobe, confirmation dispatch and gaps.
    always_comb begin
        state_d       = state_q;
        fin_d         = fin_q;
        finValid_d    = 1'b0;
        grant_d       = grant_q;
        done_d        = 2'b00;
        fail_d        = 2'b00;
        fatal_d       = 1'b0;
        retry_d       = retry_q;
        timer_d       = timer_q;
        gapCnt_d      = gapCnt_q;
        ptr_d         = ptr_q;
        resend_d      = resend_q;
        sel           = 1'b0;
        attemptFailed = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((req != 2'b00) && !link_busy) begin
                    sel      = req[ptr_q] ? ptr_q : ~ptr_q;
                    grant_d  = sel ? 2'b10 : 2'b01;
                    fin_d    = sel ? frame1 : frame0;
                    retry_d  = '0;
                    resend_d = 1'b0;
                    state_d  = S_SEND;
                end
            end

            S_SEND: begin
                finValid_d = 1'b1;
                timer_d    = '0;
                state_d    = S_WAIT_CONF;
            end

            S_WAIT_CONF: begin
                if (timer_q != TIMER_SAT) begin
                    timer_d = timer_q + 32'd1;
                end
                if (confRise) begin
                    case (conf_from_PC)
                        OKAY: begin
                            done_d   = grant_q;
                            ptr_d    = grant_q[0];
                            gapCnt_d = '0;
                            state_d  = S_GAP;
                        end
                        FATAL_ERROR: begin
                            fail_d   = grant_q;
                            fatal_d  = 1'b1;
                            grant_d  = 2'b00;
                            gapCnt_d = '0;
                            state_d  = S_FATAL;
                        end
                        ERROR:   attemptFailed = 1'b1;
                        default: attemptFailed = 1'b1;
                    endcase
                end else if (timer_q >= TIMER_LAST) begin
                    attemptFailed = 1'b1;
                end

                if (attemptFailed) begin
                    gapCnt_d = '0;
                    state_d  = S_GAP;
                    if (retry_q < RETRY_MAX) begin
                        retry_d  = retry_q + 1'b1;
                        resend_d = 1'b1;
                    end else begin
                        fail_d   = grant_q;
                        ptr_d    = grant_q[0];
                        resend_d = 1'b0;
                    end
                end
            end

            S_GAP: begin
                if (gapCnt_q >= GAP_LAST) begin
                    if (resend_q) begin
                        resend_d = 1'b0;
                        state_d  = S_SEND;
                    end else begin
                        grant_d = 2'b00;
                        state_d = S_IDLE;
                    end
                end else begin
                    gapCnt_d = gapCnt_q + 32'd1;
                end
            end

            S_FATAL: begin
                grant_d = 2'b00;
                if (gapCnt_q >= GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 32'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_link_arbiter.sv
// Directed testbench for frame_link_arbiter: single request, round-robin,
// retry exhaustion, fatal abort, busy link with timeout, and mid-flight reset.

module tb_frame_link_arbiter;

    localparam int FS      = 31;
    localparam int RETRIES = 3;
    localparam int TMO     = 50;
    localparam int GAP     = 8;

    logic          clk;
    logic          init;
    logic [1:0]    req;
    logic [0:FS]   frame0;
    logic [0:FS]   frame1;
    logic [1:0]    done;
    logic [1:0]    fail;
    logic [1:0]    grant;
    logic          fatal;
    logic [0:FS]   fin;
    logic          fin_valid;
    logic          link_busy;
    logic [7:0]    conf_from_PC;
    logic          conf_from_PC_valid;

    int vectorCount = 0;
    int missCount   = 0;
    int strobeCount = 0;
    int doneCount   = 0;
    int failCount   = 0;

    localparam logic [0:FS] PAT_A = 32'hA5C3_0F11;
    localparam logic [0:FS] PAT_B = 32'h3C96_E722;

    frame_link_arbiter #(
        .FRAME_SIZE     (FS),
        .MAX_RETRY      (RETRIES),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP),
        .OKAY           (8'h05),
        .ERROR          (8'h04),
        .FATAL_ERROR    (8'h08)
    ) dut (
        .clk                (clk),
        .init               (init),
        .req                (req),
        .frame0             (frame0),
        .frame1             (frame1),
        .done               (done),
        .fail               (fail),
        .grant              (grant),
        .fatal              (fatal),
        .fin                (fin),
        .fin_valid          (fin_valid),
        .link_busy          (link_busy),
        .conf_from_PC       (conf_from_PC),
        .conf_from_PC_valid (conf_from_PC_valid)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Event counters, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (fin_valid) strobeCount++;
        if (done != 2'b00) doneCount++;
        if (fail != 2'b00) failCount++;
    end

    // Hard stop in case the bench itself loses its way.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic busy);
        req       = r;
        link_busy = busy;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic doReset();
        init = 1'b1;
        conf_from_PC_valid = 1'b0;
        applyStimulus(2'b00, 1'b0);
        tick(2);
        init = 1'b0;
        tick(1);
    endtask

    // Advance at least one cycle, then until fin_valid is seen or the bound expires.
    task automatic waitStrobe(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fin_valid !== 1'b1 && n < bound);
        if (fin_valid !== 1'b1) checkOutput("strobeTimeout", 32'(n), 32'(bound + 1));
    endtask

    // Raise a confirmation, check the registered response and its one-cycle width.
    task automatic sendConf(input logic [7:0] code, input logic [1:0] expDone,
                            input logic [1:0] expFail, input logic expFatal);
        conf_from_PC       = code;
        conf_from_PC_valid = 1'b1;
        @(negedge clk);
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("fail", 32'(fail), 32'(expFail));
        checkOutput("fatal", 32'(fatal), 32'(expFatal));
        @(negedge clk);
        checkOutput("pulseWidth", 32'({done, fail, fatal}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        conf_from_PC_valid = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        int d0;
        int f0;
        logic [1:0] expGrant;

        init = 1'b1;
        req = 2'b00;
        frame0 = PAT_A;
        frame1 = PAT_B;
        link_busy = 1'b0;
        conf_from_PC = 8'h00;
        conf_from_PC_valid = 1'b0;

        // Reset values
        tick(2);
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstFin", 32'(fin), 32'd0);
        checkOutput("rstFinValid", 32'(fin_valid), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstFail", 32'(fail), 32'd0);
        checkOutput("rstFatal", 32'(fatal), 32'd0);
        init = 1'b0;
        tick(1);

        // Confirmation rise while idle is ignored
        d0 = doneCount; f0 = failCount;
        conf_from_PC = 8'h05; conf_from_PC_valid = 1'b1;
        tick(3);
        conf_from_PC_valid = 1'b0;
        tick(1);
        checkOutput("idleConfDone", 32'(doneCount - d0), 32'd0);
        checkOutput("idleConfFail", 32'(failCount - f0), 32'd0);
        checkOutput("idleConfGrant", 32'(grant), 32'd0);

        // Single request, OKAY
        applyStimulus(2'b01, 1'b0);
        tick(1);
        checkOutput("t1Grant", 32'(grant), 32'b01);
        checkOutput("t1Fin", 32'(fin), 32'(PAT_A));
        checkOutput("t1NoStrobeYet", 32'(fin_valid), 32'd0);
        tick(1);
        checkOutput("t1Strobe", 32'(fin_valid), 32'd1);
        checkOutput("t1FinAtStrobe", 32'(fin), 32'(PAT_A));
        tick(1);
        checkOutput("t1StrobeWidth", 32'(fin_valid), 32'd0);
        sendConf(8'h05, 2'b01, 2'b00, 1'b0);
        applyStimulus(2'b00, 1'b0);
        tick(GAP - 4);
        checkOutput("t1GrantInGap", 32'(grant), 32'b01);
        tick(1);
        checkOutput("t1GrantCleared", 32'(grant), 32'd0);
        checkOutput("t1FinHeld", 32'(fin), 32'(PAT_A));
        tick(3);

        // Contention and round-robin from a fresh pointer
        doReset();
        s0 = strobeCount; d0 = doneCount;
        applyStimulus(2'b11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
            waitStrobe(GAP + 10, n);
            checkOutput($sformatf("rrGrant%0d", i), 32'(grant), 32'(expGrant));
            checkOutput($sformatf("rrFin%0d", i), 32'(fin), (i % 2 == 0) ? 32'(PAT_A) : 32'(PAT_B));
            tick(1);
            sendConf(8'h05, expGrant, 2'b00, 1'b0);
        end
        applyStimulus(2'b00, 1'b0);
        tick(GAP + 5);
        checkOutput("rrStrobes", 32'(strobeCount - s0), 32'd4);
        checkOutput("rrDones", 32'(doneCount - d0), 32'd4);
        checkOutput("rrIdle", 32'(grant), 32'd0);

        // Retry exhaustion on ERROR
        s0 = strobeCount; d0 = doneCount; f0 = failCount;
        applyStimulus(2'b10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            waitStrobe(GAP + 10, n);
            if (i > 0) checkOutput($sformatf("retryGap%0d", i), 32'(n), 32'(GAP - 2));
            checkOutput($sformatf("retryGrant%0d", i), 32'(grant), 32'b10);
            checkOutput($sformatf("retryFin%0d", i), 32'(fin), 32'(PAT_B));
            tick(1);
            sendConf(8'h04, 2'b00, (i == 3) ? 2'b10 : 2'b00, 1'b0);
        end
        applyStimulus(2'b00, 1'b0);
        tick(GAP + 5);
        checkOutput("retryStrobes", 32'(strobeCount - s0), 32'd4);
        checkOutput("retryNoDone", 32'(doneCount - d0), 32'd0);
        checkOutput("retryFails", 32'(failCount - f0), 32'd1);

        // Fatal abort, then the other pending request is served
        applyStimulus(2'b11, 1'b0);
        waitStrobe(GAP + 10, n);
        checkOutput("fatalOwner", 32'(grant), 32'b01);
        tick(1);
        sendConf(8'h08, 2'b00, 2'b01, 1'b1);
        applyStimulus(2'b10, 1'b0);
        waitStrobe(GAP + 10, n);
        checkOutput("fatalHold", 32'(n), 32'(GAP - 1));
        checkOutput("fatalNextGrant", 32'(grant), 32'b10);
        checkOutput("fatalNextFin", 32'(fin), 32'(PAT_B));
        tick(1);
        sendConf(8'h05, 2'b10, 2'b00, 1'b0);
        applyStimulus(2'b00, 1'b0);
        tick(GAP + 5);

        // Busy link blocks the grant, then timeouts drive retries to failure
        s0 = strobeCount;
        applyStimulus(2'b01, 1'b1);
        tick(10);
        checkOutput("busyNoStrobe", 32'(strobeCount - s0), 32'd0);
        checkOutput("busyNoGrant", 32'(grant), 32'd0);
        applyStimulus(2'b01, 1'b0);
        waitStrobe(10, n);
        checkOutput("busyRelease", 32'(n), 32'd2);
        for (int i = 1; i < 4; i++) begin
            waitStrobe(TMO + GAP + 10, n);
            checkOutput($sformatf("tmoPeriod%0d", i), 32'(n), 32'(TMO + GAP + 1));
            checkOutput($sformatf("tmoFin%0d", i), 32'(fin), 32'(PAT_A));
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fail == 2'b00 && n < TMO + 10);
        checkOutput("tmoFailDelay", 32'(n), 32'(TMO));
        checkOutput("tmoFail", 32'(fail), 32'b01);
        applyStimulus(2'b00, 1'b0);
        tick(GAP + 5);
        checkOutput("tmoStrobes", 32'(strobeCount - s0), 32'd4);

        // Reset during WAIT_CONF
        applyStimulus(2'b11, 1'b0);
        waitStrobe(10, n);
        checkOutput("rstMidOwner", 32'(grant), 32'b10);
        d0 = doneCount; f0 = failCount;
        init = 1'b1;
        #1;
        checkOutput("rstMidFinValid", 32'(fin_valid), 32'd0);
        checkOutput("rstMidGrant", 32'(grant), 32'd0);
        checkOutput("rstMidFin", 32'(fin), 32'd0);
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        checkOutput("rstPtrGrant", 32'(grant), 32'b01);
        checkOutput("rstNoDone", 32'(doneCount - d0), 32'd0);
        checkOutput("rstNoFail", 32'(failCount - f0), 32'd0);
        waitStrobe(10, n);
        tick(1);
        sendConf(8'h05, 2'b01, 2'b00, 1'b0);
        applyStimulus(2'b00, 1'b0);
        tick(GAP + 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
